// File: rtl/phys_reg_file.sv
// phys_reg_file: physical register file with 2 read ports, NUM_WB_PORTS writeback ports and a busy scoreboard
// Define PRF_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module phys_reg_file #(
  parameter int NUM_PREGS    = 64,
  parameter int NUM_WB_PORTS = 2,
  localparam int PREG_W      = $clog2(NUM_PREGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PREG_W-1:0]              src1_reg,
  input  logic [PREG_W-1:0]              src2_reg,
  output logic [31:0]                    src1_val,
  output logic [31:0]                    src2_val,
  output logic                           src1_ready,
  output logic                           src2_ready,
  input  logic                           alloc_valid,
  input  logic [PREG_W-1:0]              alloc_preg,
  input  logic [NUM_WB_PORTS-1:0]        wb_valid,
  input  logic [NUM_WB_PORTS*PREG_W-1:0] wb_preg,
  input  logic [NUM_WB_PORTS*32-1:0]     wb_data,
  input  logic                           flush
);
  logic [31:0]          regs [NUM_PREGS];
  logic [NUM_PREGS-1:0] busy, busy_nxt;
  logic [PREG_W-1:0]    wp [NUM_WB_PORTS];
  logic [31:0]          wd [NUM_WB_PORTS];
  logic [PREG_W-1:0]    rs [2];
  logic [31:0]          rv [2];
  logic                 rr [2];
  for (genvar g = 0; g < NUM_WB_PORTS; g++) begin : g_wb
    assign wp[g] = wb_preg[g*PREG_W +: PREG_W];
    assign wd[g] = wb_data[g*32 +: 32];
  end
  assign rs[0] = src1_reg;
  assign rs[1] = src2_reg;
  assign src1_val   = rv[0];
  assign src2_val   = rv[1];
  assign src1_ready = rr[0];
  assign src2_ready = rr[1];
  // later assignments override earlier ones: flush > alloc > wb clear > hold
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NUM_WB_PORTS; i++)
      if (wb_valid[i]) busy_nxt[wp[i]] = 1'b0;
    if (alloc_valid) busy_nxt[alloc_preg] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int k = 0; k < NUM_PREGS; k++) regs[k] <= '0;
    end else begin
      busy <= busy_nxt;
      for (int i = 0; i < NUM_WB_PORTS; i++)
        if (wb_valid[i] && wp[i] != '0) regs[wp[i]] <= wd[i];
    end
  end
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rv[p] = regs[rs[p]];
      rr[p] = ~busy[rs[p]];
`ifdef PRF_BYPASS_EN
      for (int i = 0; i < NUM_WB_PORTS; i++)
        if (wb_valid[i] && wp[i] == rs[p]) begin
          rv[p] = wd[i];
          rr[p] = 1'b1;
        end
`endif
      if (rs[p] == '0 || !rst_n) begin
        rv[p] = '0;
        rr[p] = 1'b1;
      end
    end
  end
`ifndef SYNTHESIS
  logic wb_clash;
  always_comb begin
    wb_clash = 1'b0;
    for (int i = 0; i < NUM_WB_PORTS; i++)
      for (int j = i + 1; j < NUM_WB_PORTS; j++)
        if (wb_valid[i] && wb_valid[j] && wp[i] == wp[j] && wp[i] != '0) wb_clash = 1'b1;
  end
  always_ff @(posedge clk)
    if (rst_n) assert (!wb_clash) else $error("phys_reg_file: writeback ports collide on one preg");
`endif
endmodule

// File: tb/tb_phys_reg_file.sv
// tb_phys_reg_file: scoreboard bench for phys_reg_file read ports, writeback, busy tracking and reset
module tb_phys_reg_file;
  localparam int NP = 64;
  localparam int PW = 6;
  typedef struct {
    string       name;
    int          p;
    logic [31:0] v;
    logic        r;
  } exp_t;
  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] src1_reg, src2_reg, alloc_preg;
  logic [31:0]   src1_val, src2_val;
  logic          src1_ready, src2_ready, alloc_valid, flush;
  logic [1:0]    wb_valid;
  logic [2*PW-1:0] wb_preg;
  logic [63:0]   wb_data;
  exp_t          q[$];
  exp_t          e;
  logic [32:0]   got;
  int            checks = 0;
  int            fails = 0;
  logic [31:0]   m_regs [NP];
  logic [NP-1:0] m_busy;

  phys_reg_file dut (
    .clk(clk), .rst_n(rst_n), .src1_reg(src1_reg), .src2_reg(src2_reg),
    .src1_val(src1_val), .src2_val(src2_val), .src1_ready(src1_ready), .src2_ready(src2_ready),
    .alloc_valid(alloc_valid), .alloc_preg(alloc_preg), .wb_valid(wb_valid),
    .wb_preg(wb_preg), .wb_data(wb_data), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic idle();
    alloc_valid = 0; alloc_preg = 0; wb_valid = 0; wb_preg = 0; wb_data = 0; flush = 0;
  endtask

  task automatic push(input string name, input int p, input logic [31:0] v, input logic r);
    exp_t x;
    x.name = name; x.p = p; x.v = v; x.r = r;
    q.push_back(x);
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle(); rst_n = 0; src1_reg = 5; src2_reg = 0;
    push("reset_hold", 0, 32'h0, 1'b1);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
      if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, {e.r, e.v}); end
    end
    @(negedge clk); rst_n = 1;
    push("reset_release", 0, 32'h0, 1'b1);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
      if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, {e.r, e.v}); end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    wb_valid = 2'b11; wb_preg = {6'd8, 6'd7}; wb_data = {32'h0000_8888, 32'hDEAD_BEEF};
    @(negedge clk);
    idle(); src1_reg = 8; src2_reg = 7;
    push("wr_port0", 1, 32'hDEAD_BEEF, 1'b1);
    push("wr_port1", 0, 32'h0000_8888, 1'b1);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
      if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, {e.r, e.v}); end
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    alloc_valid = 1; alloc_preg = 9;
    @(negedge clk);
    idle(); src1_reg = 9;
    push("sb_busy", 0, 32'h0, 1'b0);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
      if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, {e.r, e.v}); end
    end
    wb_valid = 2'b10; wb_preg = {6'd9, 6'd0}; wb_data = {32'h0000_1234, 32'h0};
    @(negedge clk);
    idle();
    push("sb_ready", 0, 32'h0000_1234, 1'b1);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
      if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, {e.r, e.v}); end
    end
  endtask

  task automatic test_preg0();
    @(negedge clk);
    wb_valid = 2'b01; wb_preg = {6'd0, 6'd0}; wb_data = {32'h0, 32'hFFFF_FFFF};
    alloc_valid = 1; alloc_preg = 0; src1_reg = 0; src2_reg = 0;
    push("p0_same_cycle", 0, 32'h0, 1'b1);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
      if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, {e.r, e.v}); end
    end
    @(negedge clk);
    idle();
    push("p0_src1", 0, 32'h0, 1'b1);
    push("p0_src2", 1, 32'h0, 1'b1);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
      if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, {e.r, e.v}); end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wb_valid = 2'b01; wb_preg = {6'd0, 6'd3}; wb_data = {32'h0, 32'hA5A5_A5A5}; src1_reg = 3;
`ifdef PRF_BYPASS_EN
    push("byp_same_cycle", 0, 32'hA5A5_A5A5, 1'b1);
`else
    push("byp_same_cycle", 0, 32'h0, 1'b1);
`endif
    #2;
    while (q.size() > 0) begin
      e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
      if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, {e.r, e.v}); end
    end
    @(negedge clk);
    idle();
    push("byp_next_cycle", 0, 32'hA5A5_A5A5, 1'b1);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
      if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, {e.r, e.v}); end
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    alloc_valid = 1; alloc_preg = 4; wb_valid = 2'b01; wb_preg = {6'd0, 6'd4}; wb_data = {32'h0, 32'h0000_0044};
    @(negedge clk);
    idle(); alloc_valid = 1; alloc_preg = 10;
    @(negedge clk);
    idle(); src1_reg = 4; src2_reg = 10;
    push("alloc_wb_busy", 0, 32'h0000_0044, 1'b0);
    push("alloc_only_busy", 1, 32'h0, 1'b0);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
      if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, {e.r, e.v}); end
    end
    flush = 1; alloc_valid = 1; alloc_preg = 4;
    wb_valid = 2'b10; wb_preg = {6'd11, 6'd0}; wb_data = {32'h0000_00BB, 32'h0};
    @(negedge clk);
    idle(); src2_reg = 11;
    push("flush_beats_alloc", 0, 32'h0000_0044, 1'b1);
    push("flush_wb_data", 1, 32'h0000_00BB, 1'b1);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
      if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, {e.r, e.v}); end
    end
    src2_reg = 10;
    push("flush_clears_other", 1, 32'h0, 1'b1);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
      if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, {e.r, e.v}); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    alloc_valid = 1; alloc_preg = 12; src1_reg = 7; src2_reg = 12;
    @(negedge clk);
    idle(); src1_reg = 7; src2_reg = 12;
    wb_valid = 2'b01; wb_preg = {6'd0, 6'd12}; wb_data = {32'h0, 32'h1212_1212}; alloc_valid = 1; alloc_preg = 7;
    rst_n = 0;
    push("rst_mid_data", 0, 32'h0, 1'b1);
    push("rst_mid_busy", 1, 32'h0, 1'b1);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
      if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, {e.r, e.v}); end
    end
    @(posedge clk);
    @(negedge clk);
    idle(); rst_n = 1;
    push("rst_after_data", 0, 32'h0, 1'b1);
    push("rst_after_busy", 1, 32'h0, 1'b1);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
      if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s: got %h expected %h", e.name, got, {e.r, e.v}); end
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] p0, p1, s;
    logic [31:0]   v;
    logic          r;
    @(negedge clk);
    idle(); rst_n = 0;
    #2 rst_n = 1;
    for (int k = 0; k < NP; k++) m_regs[k] = '0;
    m_busy = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      alloc_valid = $urandom_range(0, 1);
      alloc_preg  = PW'($urandom_range(0, 15));
      wb_valid    = 2'($urandom_range(0, 3));
      p0 = PW'($urandom_range(0, 15));
      p1 = PW'($urandom_range(0, 15));
      if (wb_valid == 2'b11 && p0 == p1) p1 = p0 ^ 6'd1;
      wb_preg = {p1, p0};
      wb_data = {$urandom(), $urandom()};
      flush = ($urandom_range(0, 15) == 0);
      src1_reg = PW'($urandom_range(0, 15));
      src2_reg = PW'($urandom_range(0, 15));
      for (int p = 0; p < 2; p++) begin
        s = p ? src2_reg : src1_reg;
        v = m_regs[s];
        r = ~m_busy[s];
`ifdef PRF_BYPASS_EN
        if (wb_valid[0] && p0 == s) begin v = wb_data[31:0]; r = 1'b1; end
        if (wb_valid[1] && p1 == s) begin v = wb_data[63:32]; r = 1'b1; end
`endif
        if (s == 0) begin v = 0; r = 1'b1; end
        push(p ? "rand_src2" : "rand_src1", p, v, r);
      end
      #2;
      while (q.size() > 0) begin
        e = q.pop_front(); got = e.p ? {src2_ready, src2_val} : {src1_ready, src1_val}; checks++;
        if (got !== {e.r, e.v}) begin fails++; $display("FAIL %s cycle %0d: got %h expected %h", e.name, n, got, {e.r, e.v}); end
      end
      if (wb_valid[0] && p0 != 0) begin m_regs[p0] = wb_data[31:0]; m_busy[p0] = 1'b0; end
      if (wb_valid[1] && p1 != 0) begin m_regs[p1] = wb_data[63:32]; m_busy[p1] = 1'b0; end
      if (alloc_valid && alloc_preg != 0) m_busy[alloc_preg] = 1'b1;
      if (flush) m_busy = '0;
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle(); rst_n = 0; src1_reg = 0; src2_reg = 0;
    test_reset();
    test_write_read();
    test_scoreboard();
    test_preg0();
    test_bypass();
    test_collision();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
